// File: rtl/spram_arb_pkg.sv
// Shared types and constants for the two-requester SPRAM arbiter.
package spram_arb_pkg;

  localparam int unsigned SPRAM_ADDR_W = 15;
  localparam int unsigned SPRAM_DATA_W = 8;

  typedef enum logic {
    OWNER_0 = 1'b0,
    OWNER_1 = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic                    we;
    logic [SPRAM_ADDR_W-1:0] addr;
    logic [SPRAM_DATA_W-1:0] wdata;
  } mem_cmd_t;

  // One slot of the read-return tracking pipeline
  typedef struct packed {
    logic       valid;
    arb_owner_t owner;
  } rd_tag_t;

endpackage

// File: rtl/spram_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with a registered last-grant pointer.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  arb_owner_t last_gnt_d, last_gnt_q;

  // On contention the requester that did not win last time is served
  always_comb begin
    gnt        = 2'b00;
    last_gnt_d = last_gnt_q;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt_q == OWNER_0) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt[0]) begin
      last_gnt_d = OWNER_0;
    end else if (gnt[1]) begin
      last_gnt_d = OWNER_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= OWNER_1;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one byte-wide single-port memory between two requesters, returning
// each read byte to its issuer two cycles after the grant.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = SPRAM_ADDR_W,
  parameter int unsigned DATA_W = SPRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  logic [1:0]  gnt;
  mem_cmd_t    win_cmd;
  arb_owner_t  win_owner;
  mem_cmd_t    cmd_d, cmd_q;
  rd_tag_t     s1_d, s1_q;
  logic              rvalid0_d, rvalid0_q;
  logic              rvalid1_d, rvalid1_q;
  logic [DATA_W-1:0] rdata0_d, rdata0_q;
  logic [DATA_W-1:0] rdata1_d, rdata1_q;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({req1, req0}),
    .gnt   (gnt)
  );

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  // Winner's command, selected by the one-hot grant
  always_comb begin
    win_cmd   = '0;
    win_owner = OWNER_0;
    if (gnt[1]) begin
      win_cmd.we    = we1;
      win_cmd.addr  = SPRAM_ADDR_W'(addr1);
      win_cmd.wdata = SPRAM_DATA_W'(wdata1);
      win_owner     = OWNER_1;
    end else begin
      win_cmd.we    = we0;
      win_cmd.addr  = SPRAM_ADDR_W'(addr0);
      win_cmd.wdata = SPRAM_DATA_W'(wdata0);
    end
  end

  // Idle cycles keep address/data but never leave a write asserted
  always_comb begin
    cmd_d    = cmd_q;
    cmd_d.we = 1'b0;
    s1_d     = '0;
    if (|gnt) begin
      cmd_d      = win_cmd;
      s1_d.valid = ~win_cmd.we;
      s1_d.owner = win_owner;
    end
    rvalid0_d = s1_q.valid && (s1_q.owner == OWNER_0);
    rvalid1_d = s1_q.valid && (s1_q.owner == OWNER_1);
    rdata0_d  = rvalid0_d ? mem_data_out : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_data_out : rdata1_q;
  end

  // Stage 2 of the read pipeline is the rvalid/rdata register pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      s1_q      <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      cmd_q     <= cmd_d;
      s1_q      <= s1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign mem_addr    = ADDR_W'(cmd_q.addr);
  assign mem_write   = cmd_q.we;
  assign mem_data_in = DATA_W'(cmd_q.wdata);
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter: memory fixture, behavioural model
// with per-cycle comparison, and directed scenarios with literal expectations.
module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [14:0] addr0 = '0, addr1 = '0;
  logic [7:0]  wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write;
  logic [7:0]  rdata0, rdata1, mem_data_in, mem_data_out;
  logic [14:0] mem_addr;

  spram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0         (req0),
    .we0          (we0),
    .addr0        (addr0),
    .wdata0       (wdata0),
    .gnt0         (gnt0),
    .rvalid0      (rvalid0),
    .rdata0       (rdata0),
    .req1         (req1),
    .we1          (we1),
    .addr1        (addr1),
    .wdata1       (wdata1),
    .gnt1         (gnt1),
    .rvalid1      (rvalid1),
    .rdata1       (rdata1),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory fixture: asynchronous read, write on the clock edge
  logic [7:0] fmem [0:32767];
  assign mem_data_out = fmem[mem_addr];
  always @(posedge clk) if (mem_write) fmem[mem_addr] <= mem_data_in;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model state
  typedef struct { int due; int owner; int data; } pend_t;
  typedef struct { int owner; int cyc; } glog_t;
  typedef struct { int owner; int data; int cyc; } rlog_t;
  logic [7:0] ref_mem [0:32767];
  pend_t pend[$];
  glog_t glog[$];
  rlog_t rlog[$];
  int   exp_last;
  logic exp_mw;
  logic [14:0] exp_ma;
  logic [7:0]  exp_md, exp_rd0, exp_rd1;

  always @(negedge clk) begin
    logic e_g0, e_g1, e_rv0, e_rv1;
    cyc++;
    if (!rst_n) begin
      exp_last = 1; exp_mw = 1'b0; exp_ma = '0; exp_md = '0;
      exp_rd0 = '0; exp_rd1 = '0;
      pend.delete();
    end else begin
      e_rv0 = 1'b0; e_rv1 = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].owner == 0) begin e_rv0 = 1'b1; exp_rd0 = 8'(pend[0].data); end
        else                    begin e_rv1 = 1'b1; exp_rd1 = 8'(pend[0].data); end
        void'(pend.pop_front());
      end
      e_g0 = req0 && (!req1 || exp_last == 1);
      e_g1 = req1 && (!req0 || exp_last == 0);
      chk("gnt0", gnt0, e_g0);
      chk("gnt1", gnt1, e_g1);
      chk("mem_write", mem_write, exp_mw);
      chk("mem_addr", mem_addr, exp_ma);
      chk("mem_data_in", mem_data_in, exp_md);
      chk("rvalid0", rvalid0, e_rv0);
      chk("rvalid1", rvalid1, e_rv1);
      chk("rdata0", rdata0, exp_rd0);
      chk("rdata1", rdata1, exp_rd1);
      // Commands take effect in grant order; a read sees every earlier write
      exp_mw = 1'b0;
      if (e_g0 || e_g1) begin
        logic        w;
        logic [14:0] a;
        logic [7:0]  d;
        w = e_g0 ? we0 : we1;
        a = e_g0 ? addr0 : addr1;
        d = e_g0 ? wdata0 : wdata1;
        exp_last = e_g0 ? 0 : 1;
        exp_mw = w; exp_ma = a; exp_md = d;
        if (w) ref_mem[a] = d;
        else   pend.push_back('{due: cyc + 2, owner: exp_last, data: int'(ref_mem[a])});
      end
      if (gnt0 || gnt1) glog.push_back('{owner: gnt1 ? 1 : 0, cyc: cyc});
      if (rvalid0) rlog.push_back('{owner: 0, data: int'(rdata0), cyc: cyc});
      if (rvalid1) rlog.push_back('{owner: 1, data: int'(rdata1), cyc: cyc});
    end
  end

  // Drive one cycle's inputs just after the edge; returns just after the next edge
  task automatic drive(input logic r0, input logic w0, input logic [14:0] a0, input logic [7:0] d0,
                       input logic r1, input logic w1, input logic [14:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic clear_logs();
    glog.delete();
    rlog.delete();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin fmem[i] = 8'h00; ref_mem[i] = 8'h00; end
    for (int i = 0; i < 4; i++) begin fmem[i] = 8'(8'h41 + i); ref_mem[i] = 8'(8'h41 + i); end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_rdata", {rdata1, rdata0}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single write then read-back
    clear_logs();
    drive(1, 1, 15'h0005, 8'h41, 0, 0, '0, '0);
    chk("t1_mem_write", mem_write, 1);
    chk("t1_mem_addr", mem_addr, 15'h0005);
    chk("t1_mem_data_in", mem_data_in, 8'h41);
    drive(1, 0, 15'h0005, 8'h00, 0, 0, '0, '0);
    chk("t1_mem_write_rd", mem_write, 0);
    idle(1);
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata0", rdata0, 8'h41);
    chk("t1_rvalid1", rvalid1, 0);
    idle(2);
    chk("t1_rlog_n", rlog.size(), 1);

    // 2: contention after one requester-1 grant, so requester 0 leads
    drive(0, 0, '0, '0, 1, 0, 15'h0002, '0);
    idle(3);
    clear_logs();
    for (int i = 0; i < 4; i++) drive(1, 0, 15'h0000, '0, 1, 0, 15'h0001, '0);
    idle(3);
    chk("t2_glog_n", glog.size(), 4);
    chk("t2_rlog_n", rlog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size() && i < rlog.size(); i++) begin
      chk("t2_gnt_order", glog[i].owner, i % 2);
      chk("t2_rd_owner", rlog[i].owner, i % 2);
      chk("t2_rd_data", rlog[i].data, (i % 2 == 0) ? 8'h41 : 8'h42);
      chk("t2_rd_lat", rlog[i].cyc - glog[i].cyc, 2);
    end

    // 3: back-to-back reads from requester 1
    clear_logs();
    for (int i = 0; i < 4; i++) drive(0, 0, '0, '0, 1, 0, 15'(i), '0);
    idle(3);
    chk("t3_rlog_n", rlog.size(), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) begin
      chk("t3_rd_owner", rlog[i].owner, 1);
      chk("t3_rd_data", rlog[i].data, 8'h41 + i);
      if (i > 0) chk("t3_consecutive", rlog[i].cyc - rlog[i-1].cyc, 1);
    end

    // 4a: write wins the contest, read returns the new byte
    clear_logs();
    drive(1, 1, 15'h7FFF, 8'h5A, 1, 0, 15'h7FFF, '0);
    drive(0, 0, '0, '0, 1, 0, 15'h7FFF, '0);
    idle(3);
    chk("t4a_glog0", (glog.size() > 0) ? glog[0].owner : -1, 0);
    chk("t4a_rlog_n", rlog.size(), 1);
    chk("t4a_rd_data", (rlog.size() > 0) ? rlog[0].data : -1, 8'h5A);

    // 4b: read wins the contest, returns the old byte; later read sees new one
    clear_logs();
    drive(1, 0, 15'h0000, '0, 0, 0, '0, '0);
    drive(1, 1, 15'h7FFF, 8'hA5, 1, 0, 15'h7FFF, '0);
    drive(1, 1, 15'h7FFF, 8'hA5, 0, 0, '0, '0);
    drive(1, 0, 15'h7FFF, '0, 0, 0, '0, '0);
    idle(3);
    chk("t4b_rlog_n", rlog.size(), 3);
    if (rlog.size() == 3) begin
      chk("t4b_rd0", rlog[0].data, 8'h41);
      chk("t4b_rd1_owner", rlog[1].owner, 1);
      chk("t4b_rd1_old", rlog[1].data, 8'h5A);
      chk("t4b_rd2_new", rlog[2].data, 8'hA5);
    end

    // 5: idle after a write
    clear_logs();
    drive(1, 1, 15'h0100, 8'h77, 0, 0, '0, '0);
    chk("t5_mem_write", mem_write, 1);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("t5_idle_write", mem_write, 0);
      chk("t5_idle_addr", mem_addr, 15'h0100);
      chk("t5_idle_rvalid", {rvalid1, rvalid0}, 0);
    end

    // 6: asynchronous reset with a read and a write in flight
    drive(1, 0, 15'h0001, '0, 0, 0, '0, '0);
    drive(0, 0, '0, '0, 1, 1, 15'h0300, 8'h11);
    chk("t6_pre_write", mem_write, 1);
    chk("t6_pre_rvalid0", rvalid0, 1);
    req1 = 1'b0; we1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_write", mem_write, 0);
    chk("t6_rst_rvalid", {rvalid1, rvalid0}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    idle(4);
    chk("t6_no_rvalid", rlog.size(), 0);
    chk("t6_no_write_300", fmem[15'h0300], 8'h00);
    drive(1, 0, 15'h0000, '0, 1, 0, 15'h0001, '0);
    idle(3);
    chk("t6_first_gnt", (glog.size() > 0) ? glog[0].owner : -1, 0);
    chk("t6_rd_data", (rlog.size() > 0) ? rlog[0].data : -1, 8'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
